satarx_deframer: RTL and testbench
==================================

// Module: satarx_deframer
// PURPOSE
//  Receive-side inverse of the TX framer: sits between the SATA RX link
//  (33-bit words, bit 32 set = primitive) and the transport layer. Strips
//  SOF/EOF, discards HOLD/HOLDA/ALIGN/other in-frame primitives, and emits
//  the payload as 32-bit AXI-stream with TLAST on the final data word.
//  TLAST is known only when EOF arrives, so one data word is always held back.
// PARAMETERS
//  P_SOF         33'h1_7cb5_3737  start-of-frame primitive
//  P_EOF         33'h1_7cb5_d5d5  end-of-frame primitive
//  OPT_LOWPOWER  1'b0             zero TDATA/held word whenever not valid
// PORTS
//  S_AXI_ACLK     in   1   sole clock
//  S_AXI_ARESET   in   1   synchronous, active-high reset
//  S_AXIS_TVALID  in   1   link word valid
//  S_AXIS_TREADY  out  1   link word accepted
//  S_AXIS_TDATA   in   33  link word; [32]=1 means primitive
//  M_AXIS_TVALID  out  1   payload valid
//  M_AXIS_TREADY  in   1   transport ready
//  M_AXIS_TDATA   out  32  payload word
//  M_AXIS_TLAST   out  1   last word of frame
//  o_frame_err    out  1   one-cycle framing-error pulse
//  o_err_count    out  16  saturating error count (see CONFIGURATION)
// BEHAVIOUR
//  Reset (sync, active-high): state=S_IDLE, held-word valid=0, M_AXIS_TVALID=0,
//   M_AXIS_TLAST=0, o_frame_err=0, o_err_count=0; TDATA/held word=0 if
//   OPT_LOWPOWER. Reset mid-frame discards the held word; no TLAST is emitted.
//  S_AXIS_TREADY = !M_AXIS_TVALID || M_AXIS_TREADY, in every state.
//  Word accepted (acc) = S_AXIS_TVALID && S_AXIS_TREADY. M_AXIS_TVALID clears
//   on M_AXIS_TREADY unless reloaded in the same cycle.
//  States:
//   S_IDLE: acc SOF -> S_FIRST. acc data word -> dropped, o_frame_err.
//    Other primitives, including EOF -> ignored.
//   S_FIRST (in frame, nothing held): acc data -> store as held, -> S_DATA.
//    acc EOF -> empty frame, o_frame_err, -> S_IDLE. acc SOF -> stay.
//   S_DATA (one word held): acc data -> output held word (TLAST=0), store
//    new word. acc EOF -> output held word with TLAST=1, -> S_IDLE.
//    acc SOF (missing EOF) -> output held word with TLAST=1, o_frame_err,
//    -> S_FIRST.
//  Any other primitive ([32]=1, not SOF/EOF) in S_FIRST/S_DATA is consumed
//   and dropped, with no state change.
//  Latency: a data word appears on M_AXIS the cycle after the next data word,
//   EOF or SOF is accepted. The held word is never lost while the output stalls,
//   because input acceptance is gated by the output slot.
//  No reordering, no duplication; each output word corresponds 1:1 with an
//   accepted in-frame data word.
//  o_frame_err: asserted exactly one cycle per error event listed above.
// CONFIGURATION
//  Macro SATARX_ERRCNT_EN:
//   defined: o_err_count increments on each o_frame_err, saturates at 16'hffff,
//    and is cleared only by reset.
//   undefined: o_err_count tied to 16'h0 and no counter logic is built;
//    o_frame_err is unchanged.
// STRUCTURE
//  Primitive constants (SOF, EOF, HOLD, HOLDA, ALIGN, ...) belong in the shared
//   SATA link primitive include, which is also used by the TX framer.
//  State encoding is localparam-local. Single module; no sub-module warranted.
// TESTING
//  1 SOF, D0=32'h11, D1=32'h22, EOF, M_AXIS_TREADY=1 -> out 11(L=0), 22(L=1);
//    no error.
//  2 SOF, HOLD, 33'h0_aaaa, HOLDA, 33'h0_bbbb, ALIGN, EOF -> out aaaa(L=0),
//    bbbb(L=1); primitives dropped.
//  3 Same as 1 with M_AXIS_TREADY low for 5 cycles after first output ->
//    S_AXIS_TREADY low during the stall; no loss; same sequence out.
//  4 Data 33'h0_5 in IDLE -> dropped, o_frame_err pulse; SOF,EOF -> no
//    output, o_frame_err pulse; with SATARX_ERRCNT_EN o_err_count=2.
//  5 SOF,D=7,SOF,D=8,EOF -> out 7(L=1) with o_frame_err, then 8(L=1).
//  6 SOF,D=9,reset one cycle,EOF -> no output at all; state IDLE; count=0.

Source files
------------

// File: rtl/satarx_deframer_pkg.sv
// Shared SATA link primitive encodings (33-bit link words, bit 32 = primitive),
// common to the RX deframer and the TX framer.
package satarx_deframer_pkg;

   localparam int unsigned LINK_W = 33;
   localparam int unsigned DATA_W = 32;

   localparam logic [LINK_W-1:0] SATA_SOF   = 33'h1_7cb5_3737;
   localparam logic [LINK_W-1:0] SATA_EOF   = 33'h1_7cb5_d5d5;
   localparam logic [LINK_W-1:0] SATA_HOLD  = 33'h1_7caa_d5d5;
   localparam logic [LINK_W-1:0] SATA_HOLDA = 33'h1_7caa_9595;
   localparam logic [LINK_W-1:0] SATA_ALIGN = 33'h1_bc4a_4a7b;

endpackage

// File: rtl/satarx_deframer.sv
// SATA RX deframer: strips SOF/EOF and in-frame primitives, emits payload as
// AXI-stream with TLAST. Optional error counter built when SATARX_ERRCNT_EN is defined.
module satarx_deframer
   import satarx_deframer_pkg::*;
#(
   parameter logic [LINK_W-1:0] P_SOF        = SATA_SOF,
   parameter logic [LINK_W-1:0] P_EOF        = SATA_EOF,
   parameter bit                OPT_LOWPOWER = 1'b0
) (
   input  logic              S_AXI_ACLK,
   input  logic              S_AXI_ARESET,
   input  logic              S_AXIS_TVALID,
   output logic              S_AXIS_TREADY,
   input  logic [LINK_W-1:0] S_AXIS_TDATA,
   output logic              M_AXIS_TVALID,
   input  logic              M_AXIS_TREADY,
   output logic [DATA_W-1:0] M_AXIS_TDATA,
   output logic              M_AXIS_TLAST,
   output logic              o_frame_err,
   output logic [15:0]       o_err_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FIRST = 2'd1,
      S_DATA  = 2'd2
   } state_t;

   state_t            r_state;
   logic [DATA_W-1:0] r_held;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_valid;
   logic              r_out_last;
   logic              r_frame_err;

   logic w_acc;
   logic w_is_prim;
   logic w_is_sof;
   logic w_is_eof;

   // Input is accepted only when the output slot is free or draining this cycle.
   assign S_AXIS_TREADY = !r_out_valid || M_AXIS_TREADY;
   assign w_acc         = S_AXIS_TVALID && S_AXIS_TREADY;
   assign w_is_prim     = S_AXIS_TDATA[LINK_W-1];
   assign w_is_sof      = (S_AXIS_TDATA == P_SOF);
   assign w_is_eof      = (S_AXIS_TDATA == P_EOF);

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         r_state     <= S_IDLE;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_frame_err <= 1'b0;
         if (OPT_LOWPOWER) begin
            r_out_data <= '0;
            r_held     <= '0;
         end
      end else begin
         r_frame_err <= 1'b0;
         if (r_out_valid && M_AXIS_TREADY) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (OPT_LOWPOWER)
               r_out_data <= '0;
         end
         if (w_acc) begin
            case (r_state)
               S_IDLE: begin
                  if (w_is_sof)
                     r_state <= S_FIRST;
                  else if (!w_is_prim)
                     r_frame_err <= 1'b1;
               end
               S_FIRST: begin
                  if (!w_is_prim) begin
                     r_held  <= S_AXIS_TDATA[DATA_W-1:0];
                     r_state <= S_DATA;
                  end else if (w_is_eof) begin
                     r_frame_err <= 1'b1;
                     r_state     <= S_IDLE;
                  end
               end
               S_DATA: begin
                  // Held word leaves once its successor (data, EOF or SOF) is known.
                  if (!w_is_prim) begin
                     r_out_valid <= 1'b1;
                     r_out_data  <= r_held;
                     r_out_last  <= 1'b0;
                     r_held      <= S_AXIS_TDATA[DATA_W-1:0];
                  end else if (w_is_eof || w_is_sof) begin
                     r_out_valid <= 1'b1;
                     r_out_data  <= r_held;
                     r_out_last  <= 1'b1;
                     r_frame_err <= w_is_sof;
                     r_state     <= w_is_sof ? S_FIRST : S_IDLE;
                     if (OPT_LOWPOWER)
                        r_held <= '0;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign M_AXIS_TVALID = r_out_valid;
   assign M_AXIS_TDATA  = r_out_data;
   assign M_AXIS_TLAST  = r_out_last;
   assign o_frame_err   = r_frame_err;

`ifdef SATARX_ERRCNT_EN
   logic [15:0] r_err_count;

   // Saturating count of framing-error pulses; cleared only by reset.
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET)
         r_err_count <= 16'h0;
      else if (r_frame_err && (r_err_count != 16'hffff))
         r_err_count <= r_err_count + 16'h1;
   end

   assign o_err_count = r_err_count;
`else
   assign o_err_count = 16'h0;
`endif

endmodule

// File: tb/tb_satarx_deframer.sv
// Scoreboard bench for satarx_deframer: directed frames, expected payload queued
// at stimulus time and checked by an independent output monitor.
module tb_satarx_deframer;
   import satarx_deframer_pkg::*;

   logic        clk = 1'b0;
   logic        areset;
   logic        s_tvalid;
   logic        s_tready;
   logic [32:0] s_tdata;
   logic        m_tvalid;
   logic        m_tready;
   logic [31:0] m_tdata;
   logic        m_tlast;
   logic        frame_err;
   logic [15:0] err_count;

   logic [32:0] exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   int          err_seen = 0;
   int          out_seen = 0;
   bit          stall_en = 1'b0;

   always #5 clk = ~clk;

   satarx_deframer dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESET  (areset),
      .S_AXIS_TVALID (s_tvalid),
      .S_AXIS_TREADY (s_tready),
      .S_AXIS_TDATA  (s_tdata),
      .M_AXIS_TVALID (m_tvalid),
      .M_AXIS_TREADY (m_tready),
      .M_AXIS_TDATA  (m_tdata),
      .M_AXIS_TLAST  (m_tlast),
      .o_frame_err   (frame_err),
      .o_err_count   (err_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: samples mid-low-phase, pops scoreboard on every output handshake.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!areset && frame_err) err_seen++;
         if (!areset && m_tvalid && m_tready) begin
            out_seen++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output actual=%0h last=%0b required=none", m_tdata, m_tlast);
            end else begin
               logic [32:0] e;
               e = exp_q.pop_front();
               check("out_data", m_tdata, e[31:0]);
               check("out_last", 32'(m_tlast), 32'(e[32]));
            end
         end
      end
   end

   // Output stall: hold M_AXIS_TREADY low for 5 cycles after the first output appears.
   initial begin
      forever begin
         @(negedge clk);
         if (stall_en && m_tvalid) begin
            stall_en = 1'b0;
            m_tready = 1'b0;
            repeat (5) begin
               #1;
               check("stall_s_tready", 32'(s_tready), 32'h0);
               @(negedge clk);
            end
            m_tready = 1'b1;
         end
      end
   end

   task automatic send(input logic [32:0] w);
      bit ok;
      ok       = 1'b0;
      s_tdata  = w;
      s_tvalid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         #1;
         ok = s_tready;
         @(posedge clk);
         @(negedge clk);
      end
      s_tvalid = 1'b0;
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL send_timeout actual=not_accepted required=accepted word=%0h", w);
      end
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      check(name, 32'(exp_q.size()), 32'h0);
   endtask

   function automatic logic [32:0] exp_word(input logic [31:0] d, input logic last);
      return {last, d};
   endfunction

   function automatic logic [15:0] exp_count(input int n);
`ifdef SATARX_ERRCNT_EN
      return 16'(n);
`else
      return 16'h0 + 16'(n & 0);
`endif
   endfunction

   initial begin
      int e0;
      int o0;
      areset   = 1'b1;
      s_tvalid = 1'b0;
      s_tdata  = '0;
      m_tready = 1'b1;
      repeat (3) @(negedge clk);
      areset = 1'b0;
      #1;
      check("rst_m_tvalid", 32'(m_tvalid), 32'h0);
      check("rst_m_tlast", 32'(m_tlast), 32'h0);
      check("rst_frame_err", 32'(frame_err), 32'h0);
      check("rst_err_count", 32'(err_count), 32'h0);
      check("rst_s_tready", 32'(s_tready), 32'h1);
      @(negedge clk);

      // 1: basic two-word frame
      e0 = err_seen;
      exp_q.push_back(exp_word(32'h11, 1'b0));
      exp_q.push_back(exp_word(32'h22, 1'b1));
      send(SATA_SOF); send(33'h0_0000_0011); send(33'h0_0000_0022); send(SATA_EOF);
      drain("t1_drain");
      check("t1_err", 32'(err_seen - e0), 32'h0);

      // 2: in-frame primitives dropped
      e0 = err_seen;
      exp_q.push_back(exp_word(32'haaaa, 1'b0));
      exp_q.push_back(exp_word(32'hbbbb, 1'b1));
      send(SATA_SOF); send(SATA_HOLD); send(33'h0_0000_aaaa); send(SATA_HOLDA);
      send(33'h0_0000_bbbb); send(SATA_ALIGN); send(SATA_EOF);
      drain("t2_drain");
      check("t2_err", 32'(err_seen - e0), 32'h0);

      // 3: output stall after first word
      e0 = err_seen;
      exp_q.push_back(exp_word(32'h11, 1'b0));
      exp_q.push_back(exp_word(32'h22, 1'b1));
      stall_en = 1'b1;
      send(SATA_SOF); send(33'h0_0000_0011); send(33'h0_0000_0022); send(SATA_EOF);
      drain("t3_drain");
      check("t3_err", 32'(err_seen - e0), 32'h0);
      check("t3_stall_done", 32'(stall_en), 32'h0);

      // 4: data in IDLE, then empty frame
      e0 = err_seen;
      o0 = out_seen;
      send(33'h0_0000_0005);
      send(SATA_SOF); send(SATA_EOF);
      drain("t4_drain");
      check("t4_err", 32'(err_seen - e0), 32'h2);
      check("t4_no_output", 32'(out_seen - o0), 32'h0);
      check("t4_err_count", 32'(err_count), 32'(exp_count(2)));

      // 5: missing EOF closes the previous frame
      e0 = err_seen;
      exp_q.push_back(exp_word(32'h7, 1'b1));
      exp_q.push_back(exp_word(32'h8, 1'b1));
      send(SATA_SOF); send(33'h0_0000_0007); send(SATA_SOF); send(33'h0_0000_0008); send(SATA_EOF);
      drain("t5_drain");
      check("t5_err", 32'(err_seen - e0), 32'h1);
      check("t5_err_count", 32'(err_count), 32'(exp_count(3)));

      // 6: reset mid-frame discards the held word
      o0 = out_seen;
      send(SATA_SOF); send(33'h0_0000_0009);
      areset = 1'b1;
      @(negedge clk);
      areset = 1'b0;
      e0 = err_seen;
      send(SATA_EOF);
      drain("t6_drain");
      check("t6_no_output", 32'(out_seen - o0), 32'h0);
      check("t6_m_tvalid", 32'(m_tvalid), 32'h0);
      check("t6_err", 32'(err_seen - e0), 32'h0);
      check("t6_err_count", 32'(err_count), 32'h0);
      // Data now must be treated as out-of-frame, proving the state is IDLE.
      send(33'h0_0000_0005);
      repeat (3) @(negedge clk);
      check("t6_idle_err", 32'(err_seen - e0), 32'h1);
      check("t6_idle_no_output", 32'(out_seen - o0), 32'h0);
      check("t6_err_count_after", 32'(err_count), 32'(exp_count(1)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
